mul_div_unit: RTL and testbench

- Multi-cycle RISC-V M-extension unit in the EX stage, alongside the single-cycle ALU.
- The ALU answers in the same cycle. This block handles the long-latency operations and tells the pipeline to stall through a start/busy/done handshake.
- Takes operands already forwarded into EX. Returns one result to the EX/MEM mux.

---
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide
// sharing one hi/lo register pair, with a start/busy/done handshake toward the EX stage.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] input_data_1,
  input  logic [DATA_WIDTH-1:0] input_data_2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] output_data
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [W-1:0]         MOST_NEG = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg_wide(input logic [2*W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2:0]           op_r;
  logic                 neg_q;
  logic                 neg_r;
  logic [W-1:0]         hi;
  logic [W-1:0]         lo;
  logic [W-1:0]         mag_b;

  // Acceptance decode: operand signedness, magnitudes and division special cases
  logic         is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, special;
  logic [W-1:0] mag1, mag2, special_res;

  always_comb begin
    is_div      = op[2];
    sgn1        = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn2        = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg1        = sgn1 && input_data_1[W-1];
    neg2        = sgn2 && input_data_2[W-1];
    mag1        = cond_neg(input_data_1, neg1);
    mag2        = cond_neg(input_data_2, neg2);
    div_zero    = is_div && (input_data_2 == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                  (input_data_1 == MOST_NEG) && (input_data_2 == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = op[1] ? input_data_1 : '1;
    else if (div_ovf) special_res = op[1] ? '0 : MOST_NEG;
  end

  // One iteration step for both algorithms
  logic [W:0]   mul_sum, div_shift, div_diff;
  logic         div_ge;
  logic [W-1:0] hi_next, lo_next;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {hi, lo[W-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = !div_diff[W];
    if (op_r[2]) begin
      hi_next = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      lo_next = {lo[W-2:0], div_ge};
    end else begin
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo[W-1:1]};
    end
  end

  // Sign correction and half selection applied in FIX
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod_fix = cond_neg_wide({hi, lo}, neg_q);
    if (op_r[2])               fix_res = op_r[1] ? cond_neg(hi, neg_r) : cond_neg(lo, neg_q);
    else if (op_r == OP_MUL)   fix_res = prod_fix[W-1:0];
    else                       fix_res = prod_fix[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_r        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      mag_b       <= '0;
      output_data <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r  <= op;
          neg_q <= neg1 ^ neg2;
          neg_r <= neg1;
          hi    <= '0;
          cnt   <= '0;
          lo    <= is_div ? mag1 : mag2;
          mag_b <= is_div ? mag2 : mag1;
          if (special) begin
            output_data <= special_res;
            state       <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= S_FIX;
        end
        S_FIX: begin
          output_data <= fix_res;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with per-cycle compare, plus
// directed literal cases and randomized operations, flushes and ignored starts.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          flush;
  logic [2:0]    op;
  logic [W-1:0]  d1, d2;
  logic          busy, done;
  logic [W-1:0]  out;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 0;
  logic [W-1:0] last_exp = '0;

  mul_div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .input_data_1(d1), .input_data_2(d2),
    .busy(busy), .done(done), .output_data(out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, p, q;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (o)
      3'b000: return up[31:0];
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'b011: return up[63:32];
      3'b100: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        q = sa / sb; return q[31:0];
      end
      3'b101: return (b == 0) ? '1 : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference model: cycles remaining until the done cycle (0 = idle) and expected output
  int           m_left = 0;
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_res  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_out  = '0;
    end else if (flush) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) m_out = m_res;
    end else if (start) begin
      m_res  = ref_result(op, d1, d2);
      m_left = is_special(op, d1, d2) ? 1 : W + 2;
      if (m_left == 1) m_out = m_res;
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, m_left > 0});
      check("cyc_done", {31'b0, done}, {31'b0, m_left == 1});
      check("cyc_out", out, m_out);
    end
  end

  // Issue one op; optionally pulse start again at busy cycle 'poke'; check latency and result
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat, input int poke, input string nm);
    int k;
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); d1 = $urandom; d2 = $urandom;
    k = 1;
    while (!done && k < 60) begin
      start = (k == poke);
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check({nm, "_done"}, {31'b0, done}, 32'd1);
    check({nm, "_lat"}, W'(k), W'(lat));
    check({nm, "_out"}, out, exp);
    last_exp = exp;
  endtask

  task automatic flush_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int fc, input string nm);
    int seen;
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < fc; k++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check({nm, "_busy"}, {31'b0, busy}, 32'd0);
    check({nm, "_out"}, out, last_exp);
    seen = 0;
    for (int k = 0; k < W + 6; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check({nm, "_nodone"}, W'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a, b;
    int           seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out", out, 32'd0);
    rst = 1'b0;
    run_cmp = 1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, "rem");
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 0, "divu");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, 0, "remu");
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_z");
    run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, 0, "remu_z");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");
    run_op(3'b000, 32'd6, 32'd9, 32'd54, 34, 5, "poke");
    run_op(3'b101, 32'd1000, 32'd10, 32'd100, 34, 0, "b2b");
    flush_op(3'b000, 32'd3, 32'd4, 10, "flush");

    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; d1 = 32'd2; d2 = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("sf_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < W + 6; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("sf_nodone", W'(seen), 32'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = 3'b011; d1 = 32'h1234_5678; d2 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_out", out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;
    seen = 0;
    for (int k = 0; k < W + 6; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("arst_nodone", W'(seen), 32'd0);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      case ($urandom_range(0, 5))
        0: a = '0;
        1: a = 32'h8000_0000;
        2: a = '1;
        3: a = W'($urandom_range(0, 9));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'h8000_0000;
        2: b = '1;
        3: b = W'($urandom_range(0, 9));
        default: b = $urandom;
      endcase
      if (!is_special(o, a, b) && $urandom_range(0, 5) == 0)
        flush_op(o, a, b, $urandom_range(1, 33), "rnd_flush");
      else
        run_op(o, a, b, ref_result(o, a, b), is_special(o, a, b) ? 1 : 34,
               $urandom_range(0, 40), "rnd");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
